// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch, PC ownership and the IF/ID register.
// Issues one imem read at a time, parks a stalled response, applies redirects.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   stall                 hazard unit: IF/ID holds its contents
//   redirect, redirect_pc taken branch / jump target from later stages
//   imem_req, imem_addr   one-cycle read request and its address
//   imem_rvalid, imem_rdata  read response
//   ifid_valid, ifid_instr, ifid_pc4, ifid_opcode  IF/ID register outputs
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  ifid_opcode
);

    typedef enum logic [1:0] {
        S_RESET,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        kill;
    logic [31:0] hbuf_instr;
    logic [31:0] hbuf_pc4;
    logic        ld_mem;
    logic        ld_hbuf;
    logic        unused_pc_lsb;

    // Targets are word aligned; the two low bits carry no information.
    assign target        = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign pc_plus4      = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RESET: state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (redirect) begin
                    state_nxt = imem_rvalid ? S_ISSUE : S_WAIT;
                end else if (imem_rvalid) begin
                    state_nxt = (kill || !stall) ? S_ISSUE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    state_nxt = S_ISSUE;
                end
            end
            default: state_nxt = S_RESET;
        endcase
    end

    // Request outputs depend on state and pc only.
    always_comb begin
        imem_req  = (state == S_ISSUE);
        imem_addr = pc;
    end

    always_comb begin
        ld_mem  = (state == S_WAIT) && imem_rvalid && !redirect
                  && !kill && !stall;
        ld_hbuf = (state == S_HOLD) && !redirect && !stall;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= PC_RESET;
            kill       <= 1'b0;
            hbuf_instr <= 32'h0;
            hbuf_pc4   <= 32'h0;
        end else begin
            unique case (state)
                S_ISSUE: begin
                    // The request still goes out; its response is dropped.
                    if (redirect) begin
                        pc   <= target;
                        kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc   <= target;
                        kill <= !imem_rvalid;
                    end else if (imem_rvalid) begin
                        if (kill) begin
                            // pc already holds the redirect target.
                            kill <= 1'b0;
                        end else begin
                            pc <= pc_plus4;
                            if (stall) begin
                                hbuf_instr <= imem_rdata;
                                hbuf_pc4   <= pc_plus4;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc <= target;
                    end
                end
                default: ;
            endcase
        end
    end

    // Redirect squashes even under stall; otherwise a stall freezes IF/ID.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_pc4   <= 32'h0;
        end else if (redirect) begin
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            if (ld_mem) begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem_rdata;
                ifid_pc4   <= pc_plus4;
            end else if (ld_hbuf) begin
                ifid_valid <= 1'b1;
                ifid_instr <= hbuf_instr;
                ifid_pc4   <= hbuf_pc4;
            end else begin
                ifid_valid <= 1'b0;
            end
        end
    end

    assign ifid_opcode = ifid_instr[31:26];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS core; it sits directly upstream of the main decoder `control`, whose `opcode` input is driven from `ifid_opcode`. The block owns the PC and issues one instruction-memory read at a time over a request/valid handshake. It captures each returned word into IF/ID and applies stall and redirect (taken branch / jump) from later stages. A single-entry hold buffer absorbs a response that arrives while IF/ID is stalled.

## Interface
- `PC_RESET`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `stall`  in  1: hazard unit; IF/ID must hold its contents.
- `redirect`  in  1: taken beq/bne or jump resolved downstream.
- `redirect_pc`  in  32: new fetch address; bits [1:0] are ignored and treated as 00.
- `imem_req`  out  1: read request, one-cycle pulse.
- `imem_addr`  out  32: read address, equal to `pc` while `imem_req` is 1.
- `imem_rvalid`  in  1: read data valid; at most one response per request, at least 1 cycle after the request.
- `imem_rdata`  in  32: instruction word.
- `ifid_valid`  out  1: IF/ID holds a live instruction.
- `ifid_instr`  out  32: fetched instruction.
- `ifid_pc4`  out  32: address of the instruction + 4.
- `ifid_opcode`  out  6: `ifid_instr[31:26]`, routed to `control.opcode`.

## Operation
- **State machine** with four states: RESET, ISSUE, WAIT, HOLD. Registers: `pc`, `kill`, hold buffer (`hbuf_instr`, `hbuf_pc4`).
- **RESET.** Entered whenever `rst_n`=0. Always goes to ISSUE on the next cycle.
- **ISSUE.**
  - `imem_req`=1 and `imem_addr`=`pc`. Always goes to WAIT.
  - If `redirect`=1: `pc`<=`{redirect_pc[31:2],2'b00}` and `kill`<=1. The request is still issued and its response will be dropped.
- **WAIT.** Transitions evaluated in priority order:
  - `redirect`=1: `pc`<=target. If `imem_rvalid`=1 in the same cycle, drop the response, clear `kill`, go to ISSUE. Otherwise set `kill`<=1 and stay in WAIT.
  - `imem_rvalid`=1 with `kill`=1: drop the response, `kill`<=0, go to ISSUE. `pc` is unchanged because it already holds the redirect target.
  - `imem_rvalid`=1 with `stall`=0: IF/ID<=(`imem_rdata`, `pc`+4), `ifid_valid`<=1, `pc`<=`pc`+4, go to ISSUE.
  - `imem_rvalid`=1 with `stall`=1: hold buffer<=(`imem_rdata`, `pc`+4), `pc`<=`pc`+4, go to HOLD.
  - Otherwise remain in WAIT. There is no timeout.
- **HOLD.**
  - `redirect`=1: discard the buffer, `pc`<=target, go to ISSUE.
  - `stall`=0: IF/ID<=buffer, `ifid_valid`<=1, go to ISSUE.
  - Otherwise stay in HOLD.
- **IF/ID register**, in priority order:
  - `rst_n`=0: cleared.
  - `redirect`=1: `ifid_valid`<=0, even if `stall`=1.
  - `stall`=1: hold all fields.
  - Load as described above.
  - Otherwise, in any non-load cycle with `stall`=0: `ifid_valid`<=0 (bubble). `ifid_instr` and `ifid_pc4` keep their last value.
- **Arithmetic.** `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- **Outstanding requests.** At most one request is outstanding. `imem_rvalid` outside WAIT is ignored.

## Timing
- **Reset values.**
  - `imem_req`=0, `imem_addr`=`PC_RESET`.
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc4`=0, `ifid_opcode`=0.
  - `pc`=`PC_RESET`, `kill`=0, state=RESET.
- **First fetch.** The first `imem_req` occurs in the second cycle after `rst_n` rises (RESET, then ISSUE).
- **Outputs.** `imem_req` and `imem_addr` are decoded from state and `pc` only, with no combinational path from the inputs. All `ifid_*` outputs are registered.
- **Latency.** With 1-cycle memory (`imem_rvalid` the cycle after `imem_req`), an instruction appears in IF/ID 2 cycles after its request. Sustained throughput is 1 instruction per 2 cycles, with `ifid_valid` toggling 1/0.
- **Redirect.**
  - The first request to the redirect target is issued at the earliest in the cycle after the redirect (ISSUE).
  - If a stale response is still pending, the first request waits until after that response arrives.
- **Reset mid-operation.** Asserting `rst_n`=0 while in WAIT or HOLD returns the block to RESET. A late `imem_rvalid` after reset is ignored, because RESET and ISSUE do not consume responses.

## Test plan
- **Reset and straight-line fetch.** Apply reset with `PC_RESET`=0 and 1-cycle memory, where `mem[n]`=n.
  - Requests go to 0x0, 0x4, 0x8 on cycles 2, 4, 6 after reset.
  - `ifid_instr`=0,1,2, with `ifid_pc4`=0x4, 0x8, 0xC.
  - `ifid_opcode` equals `instr[31:26]`.
- **Stall with response arriving.** Assert `stall` from the cycle before `imem_rvalid` for 3 cycles.
  - IF/ID keeps its old word, and the new word is parked in HOLD.
  - The parked word loads exactly 1 cycle after `stall` drops. No word is lost or duplicated.
- **Redirect while waiting.** Apply `redirect`=1 with `redirect_pc`=0x40 in WAIT, with the response arriving the next cycle.
  - The response is dropped and `ifid_valid`=0.
  - The next request goes to 0x40, and `ifid_pc4`=0x44.
- **Redirect and rvalid in the same cycle, and misaligned target.** Use `redirect_pc`=0x43.
  - The response is dropped and the next request goes to 0x40.
- **Redirect overrides stall; redirect in HOLD.** Apply `redirect` and `stall` together.
  - `ifid_valid`=0 on the next cycle.
  - The hold buffer is discarded and the fetch resumes at the target.
- **PC wrap.** Use `PC_RESET`=32'hFFFF_FFFC.
  - The first fetch returns `ifid_pc4`=0.
  - The second request goes to 0x0.
